ofifo_drain_ctrl: RTL

OFIFO_DRAIN_CTRL -- requirements
Module: ofifo_drain_ctrl

---
 rtl/ofifo_drain_ctrl_if.sv | 44 ++++
 rtl/ofifo_drain_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/ofifo_drain_ctrl_if.sv
// ofifo_drain_ctrl_if
//   Bundles the command, ofifo handshake, SRAM write port and status
//   signals of the ofifo drain controller.
//   slave  : controller side (takes commands, drives SRAM/status)
//   master : requester side (issues commands, observes SRAM/status)
//   Signals:
//     start / base_addr / num_rows : drain command, sampled together
//     ofifo_valid                  : one pulse per completed ofifo row
//     ofifo_rd                     : ofifo read strobe
//     sram_cen / sram_wen          : active-low SRAM enables
//     sram_addr                    : SRAM write address
//     busy / done                  : controller status, done is a pulse
//     occupancy                    : full rows held in the ofifo
//     err_ovf                      : sticky overflow flag
interface ofifo_drain_ctrl_if #(
    parameter int cnt_w  = 7,
    parameter int addr_w = 11,
    parameter int len_w  = 11
);
    logic              start;
    logic [addr_w-1:0] base_addr;
    logic [len_w-1:0]  num_rows;
    logic              ofifo_valid;
    logic              ofifo_rd;
    logic              sram_cen;
    logic              sram_wen;
    logic [addr_w-1:0] sram_addr;
    logic              busy;
    logic              done;
    logic [cnt_w-1:0]  occupancy;
    logic              err_ovf;

    modport slave (
        input  start, base_addr, num_rows, ofifo_valid,
        output ofifo_rd, sram_cen, sram_wen, sram_addr,
               busy, done, occupancy, err_ovf
    );

    modport master (
        output start, base_addr, num_rows, ofifo_valid,
        input  ofifo_rd, sram_cen, sram_wen, sram_addr,
               busy, done, occupancy, err_ovf
    );
endinterface

// File: rtl/ofifo_drain_ctrl.sv
// ofifo_drain_ctrl
//   Drains num_rows completed rows from the output FIFO into the psum SRAM,
//   starting at base_addr. Tracks how many complete rows the ofifo holds,
//   reads one row per cycle while rows are available and writes each row to
//   SRAM the cycle after it was read (when ofifo read data is valid).
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-high
//     bus   : ofifo_drain_ctrl_if.slave (command, ofifo, SRAM, status)
module ofifo_drain_ctrl #(
    parameter int depth  = 64,
    parameter int cnt_w  = 7,
    parameter int addr_w = 11,
    parameter int len_w  = 11
) (
    input  logic               clk,
    input  logic               reset,
    ofifo_drain_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_LAST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [cnt_w-1:0] DEPTH_C = cnt_w'(depth);

    logic [1:0]        state;
    logic [addr_w-1:0] addr_q;
    logic [len_w-1:0]  remaining;
    logic              wr_pend;
    logic [cnt_w-1:0]  occ;
    logic              err_q;
    logic              rd;

    // Read whenever draining and a full row is present; an empty ofifo
    // simply stalls the drain.
    assign rd = (state == S_DRAIN) && (occ != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            remaining <= '0;
            wr_pend   <= 1'b0;
            occ       <= '0;
            err_q     <= 1'b0;
        end else begin
            // ofifo data appears one cycle after the read strobe.
            wr_pend <= rd;

            // A new command load takes priority over the post-write bump;
            // in IDLE no write is ever pending anyway.
            if (state == S_IDLE && bus.start)
                addr_q <= bus.base_addr;
            else if (wr_pend)
                addr_q <= addr_q + 1'b1;

            if (state == S_IDLE && bus.start)
                remaining <= bus.num_rows;
            else if (rd)
                remaining <= remaining - 1'b1;

            // Simultaneous arrival and read leave the count unchanged.
            // Arrival into a full ofifo is flagged and not counted.
            if (bus.ofifo_valid && !rd) begin
                if (occ == DEPTH_C)
                    err_q <= 1'b1;
                else
                    occ <= occ + 1'b1;
            end else if (!bus.ofifo_valid && rd) begin
                occ <= occ - 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (bus.start)
                        state <= (bus.num_rows == '0) ? S_DONE : S_DRAIN;
                end
                S_DRAIN: begin
                    // The final read leaves one write still in flight,
                    // which LAST covers.
                    if (rd && remaining == len_w'(1))
                        state <= S_LAST;
                end
                S_LAST:  state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ofifo_rd  = rd;
    assign bus.sram_cen  = ~wr_pend;
    assign bus.sram_wen  = ~wr_pend;
    assign bus.sram_addr = addr_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.occupancy = occ;
    assign bus.err_ovf   = err_q;

endmodule
